// File: rtl/uart_tx_arbiter.sv
// Four-lane round-robin arbiter in front of a single UART transmitter.
// It captures one byte from the winning lane, strobes the transmitter and
// waits for end-of-frame. If the frame never completes, it abandons the
// transfer after a bounded number of cycles.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | no owner; arbitrate among i_req & i_req_mask from ptr upward
// START   | byte captured, o_tx_start high for this single cycle
// WAIT    | waiting for i_tx_done; wait_cnt bounds the wait
module uart_tx_arbiter #(
   parameter int DATA_BITS      = 8,
   parameter int TIMEOUT_CYCLES = 200000
) (
   input  logic                   i_clk,
   input  logic                   i_reset,
   input  logic [3:0]             i_req,
   input  logic [4*DATA_BITS-1:0] i_req_data,
   input  logic [3:0]             i_req_mask,
   output logic [3:0]             o_ack,
   output logic [3:0]             o_done,
   output logic                   o_err,
   output logic [3:0]             o_grant,
   output logic                   o_busy,
   output logic                   o_tx_start,
   output logic [DATA_BITS-1:0]   o_tx_data,
   input  logic                   i_tx_done
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_WAIT  = 2'd2
   } state_t;

   // The wait counter runs 0..TIMEOUT_CYCLES-1; the last value is the abandon point.
   localparam logic [23:0] TIMEOUT_LAST = 24'(TIMEOUT_CYCLES - 1);

   state_t                 state;
   logic [1:0]             ptr;
   logic [1:0]             owner;
   logic [23:0]            wait_cnt;

   logic [3:0]             eligible;
   logic                   win_valid;
   logic [1:0]             win_idx;
   logic [3:0]             win_onehot;
   logic [DATA_BITS-1:0]   win_data;

   // Round-robin search: the first eligible lane at ptr, ptr+1, ... wins.
   // The loop runs from the farthest offset down so that the nearest one is
   // assigned last.
   always_comb begin
      eligible  = i_req & i_req_mask;
      win_valid = 1'b0;
      win_idx   = ptr;
      for (int i = 3; i >= 0; i--) begin
         if (eligible[ptr + 2'(i)]) begin
            win_valid = 1'b1;
            win_idx   = ptr + 2'(i);
         end
      end
   end

   // Select the winner's data lane and the one-hot grant pattern.
   always_comb begin
      win_onehot = 4'b0001 << win_idx;
      case (win_idx)
         2'd0:    win_data = i_req_data[0*DATA_BITS +: DATA_BITS];
         2'd1:    win_data = i_req_data[1*DATA_BITS +: DATA_BITS];
         2'd2:    win_data = i_req_data[2*DATA_BITS +: DATA_BITS];
         default: win_data = i_req_data[3*DATA_BITS +: DATA_BITS];
      endcase
   end

   // Control FSM with registered outputs. The ack, done, err and start
   // outputs are one-cycle pulses, so they default low on every edge.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state      <= ST_IDLE;
         ptr        <= 2'd0;
         owner      <= 2'd0;
         wait_cnt   <= '0;
         o_ack      <= '0;
         o_done     <= '0;
         o_err      <= 1'b0;
         o_grant    <= '0;
         o_busy     <= 1'b0;
         o_tx_start <= 1'b0;
         o_tx_data  <= '0;
      end else begin
         o_ack      <= '0;
         o_done     <= '0;
         o_err      <= 1'b0;
         o_tx_start <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (win_valid) begin
                  state      <= ST_START;
                  owner      <= win_idx;
                  o_grant    <= win_onehot;
                  o_ack      <= win_onehot;
                  o_tx_data  <= win_data;
                  o_tx_start <= 1'b1;
                  o_busy     <= 1'b1;
                  wait_cnt   <= '0;
               end
            end
            ST_START: begin
               // i_tx_done is deliberately ignored here; the frame has not started yet.
               state    <= ST_WAIT;
               wait_cnt <= '0;
            end
            ST_WAIT: begin
               // Completion takes precedence over a timeout in the same cycle.
               if (i_tx_done) begin
                  o_done   <= o_grant;
                  ptr      <= owner + 2'd1;
                  o_grant  <= '0;
                  o_busy   <= 1'b0;
                  wait_cnt <= '0;
                  state    <= ST_IDLE;
               end else if (wait_cnt == TIMEOUT_LAST) begin
                  o_err    <= 1'b1;
                  ptr      <= owner + 2'd1;
                  o_grant  <= '0;
                  o_busy   <= 1'b0;
                  wait_cnt <= '0;
                  state    <= ST_IDLE;
               end else begin
                  wait_cnt <= wait_cnt + 24'd1;
               end
            end
            default: begin
               state   <= ST_IDLE;
               o_grant <= '0;
               o_busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Testbench for uart_tx_arbiter. It checks a table of arbitration vectors,
// hand-written timing sequences (round robin, timeout, reset, serial
// frames) and randomized traffic against a transaction-level model.
module tb_uart_tx_arbiter;
   localparam int DATA_BITS = 8;
   localparam int TIMEOUT   = 16;

   logic        i_clk = 1'b0;
   logic        i_reset;
   logic [3:0]  i_req;
   logic [31:0] i_req_data;
   logic [3:0]  i_req_mask;
   logic [3:0]  o_ack;
   logic [3:0]  o_done;
   logic        o_err;
   logic [3:0]  o_grant;
   logic        o_busy;
   logic        o_tx_start;
   logic [7:0]  o_tx_data;
   logic        i_tx_done;

   logic        man_done;
   logic        uart_mode = 1'b0;
   logic        u_done;
   logic        tx_line;
   logic [9:0]  u_shift;
   int          u_left;

   int          chk_cnt  = 0;
   int          pass_cnt = 0;

   always #5 i_clk = ~i_clk;

   assign i_tx_done = uart_mode ? u_done : man_done;

   uart_tx_arbiter #(.DATA_BITS(DATA_BITS), .TIMEOUT_CYCLES(TIMEOUT)) dut (
      .i_clk      (i_clk),
      .i_reset    (i_reset),
      .i_req      (i_req),
      .i_req_data (i_req_data),
      .i_req_mask (i_req_mask),
      .o_ack      (o_ack),
      .o_done     (o_done),
      .o_err      (o_err),
      .o_grant    (o_grant),
      .o_busy     (o_busy),
      .o_tx_start (o_tx_start),
      .o_tx_data  (o_tx_data),
      .i_tx_done  (i_tx_done)
   );

   // Behavioural 8N1 transmitter with one bit per clock. It pulses u_done after the stop bit.
   always @(posedge i_clk) begin
      if (i_reset || !uart_mode) begin
         u_done  <= 1'b0;
         tx_line <= 1'b1;
         u_left  <= 0;
         u_shift <= '1;
      end else begin
         u_done <= 1'b0;
         if (u_left == 0) begin
            if (o_tx_start) begin
               u_shift <= {1'b1, o_tx_data, 1'b0};
               u_left  <= 11;
            end
         end else if (u_left == 1) begin
            u_done <= 1'b1;
            u_left <= 0;
         end else begin
            tx_line <= u_shift[0];
            u_shift <= {1'b1, u_shift[9:1]};
            u_left  <= u_left - 1;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      chk_cnt++;
      if (act !== exp)
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      else
         pass_cnt++;
   endtask

   task automatic do_reset();
      i_reset    = 1'b1;
      i_req      = 4'b0000;
      i_req_mask = 4'hF;
      man_done   = 1'b0;
      @(negedge i_clk);
      @(negedge i_clk);
      i_reset = 1'b0;
   endtask

   typedef struct {
      int         pre;
      logic [3:0] req;
      logic [3:0] mask;
      logic [3:0] exp_ack;
      logic [7:0] exp_data;
   } vec_t;

   vec_t vecs[10];

   int         m_ptr, m_owner, m_age, c, guard;
   logic [3:0] e_ack, e_done, e_grant, elig;
   logic       e_err, e_busy, e_start, err_seen;
   logic [7:0] e_data, rx;
   logic [7:0] exp_byte[3];
   logic [3:0] ack_q[$];
   logic [3:0] exp_lane;

   initial begin
      // pre: lane completed first to set ptr to pre+1 (-1: straight from reset)
      vecs[0] = '{-1, 4'b0001, 4'b1111, 4'b0001, 8'hA5};
      vecs[1] = '{-1, 4'b0110, 4'b1101, 4'b0100, 8'h33};
      vecs[2] = '{-1, 4'b0010, 4'b1101, 4'b0000, 8'h00};
      vecs[3] = '{ 0, 4'b1111, 4'b1111, 4'b0010, 8'h22};
      vecs[4] = '{ 2, 4'b1001, 4'b1111, 4'b1000, 8'h44};
      vecs[5] = '{ 2, 4'b0011, 4'b1111, 4'b0001, 8'hA5};
      vecs[6] = '{ 1, 4'b0011, 4'b1111, 4'b0001, 8'hA5};
      vecs[7] = '{-1, 4'b1000, 4'b1111, 4'b1000, 8'h44};
      vecs[8] = '{-1, 4'b0000, 4'b1111, 4'b0000, 8'h00};
      vecs[9] = '{ 3, 4'b1010, 4'b0010, 4'b0010, 8'h22};

      i_reset    = 1'b1;
      i_req      = 4'b0000;
      i_req_mask = 4'hF;
      i_req_data = 32'h0;
      man_done   = 1'b0;
      #1;
      check("reset_outputs", 64'({o_ack, o_done, o_err, o_grant, o_busy, o_tx_start, o_tx_data}), 64'd0);

      // Table-driven arbitration vectors
      for (int v = 0; v < 10; v++) begin
         do_reset();
         i_req_data = 32'h4433_22A5;
         if (vecs[v].pre >= 0) begin
            i_req = 4'b0001 << vecs[v].pre;
            @(negedge i_clk);
            i_req = 4'b0000;
            @(negedge i_clk);
            man_done = 1'b1;
            @(negedge i_clk);
            man_done = 1'b0;
         end
         i_req      = vecs[v].req;
         i_req_mask = vecs[v].mask;
         @(negedge i_clk);
         if (vecs[v].exp_ack != 4'b0000) begin
            check($sformatf("vec%0d_grant", v), 64'({o_ack, o_grant, o_tx_start, o_busy, o_tx_data}),
                  64'({vecs[v].exp_ack, vecs[v].exp_ack, 2'b11, vecs[v].exp_data}));
            i_req = 4'b0000;
            @(negedge i_clk);
            man_done = 1'b1;
            @(negedge i_clk);
            man_done = 1'b0;
            check($sformatf("vec%0d_done", v), 64'({o_done, o_busy, o_grant}),
                  64'({vecs[v].exp_ack, 1'b0, 4'b0000}));
         end else begin
            @(negedge i_clk);
            check($sformatf("vec%0d_idle", v), 64'({o_ack, o_grant, o_tx_start, o_busy}), 64'd0);
         end
         i_req = 4'b0000;
      end

      // Round robin with all four lanes requesting continuously
      do_reset();
      i_req = 4'b1111;
      for (int n = 0; n < 5; n++) begin
         exp_lane = 4'b0001 << (n % 4);
         @(negedge i_clk);
         check($sformatf("rr_ack%0d", n), 64'({o_ack, o_grant, o_tx_start}), 64'({exp_lane, exp_lane, 1'b1}));
         @(negedge i_clk);
         man_done = 1'b1;
         @(negedge i_clk);
         man_done = 1'b0;
         check($sformatf("rr_done%0d", n), 64'({o_done, o_ack, o_busy}), 64'({exp_lane, 4'b0000, 1'b0}));
      end
      i_req = 4'b0000;

      // Timeout: o_err 16 cycles after WAIT entry, then ptr advances
      do_reset();
      i_req = 4'b0001;
      @(negedge i_clk);
      check("to_ack", 64'(o_ack), 64'(4'b0001));
      i_req = 4'b0000;
      @(negedge i_clk);
      err_seen = 1'b0;
      for (int k = 1; k <= 15; k++) begin
         @(negedge i_clk);
         if (o_err || !o_busy) err_seen = 1'b1;
      end
      check("to_early", 64'(err_seen), 64'd0);
      @(negedge i_clk);
      check("to_err", 64'({o_err, o_done, o_busy, o_grant}), 64'({1'b1, 4'b0000, 1'b0, 4'b0000}));
      i_req = 4'b0011;
      @(negedge i_clk);
      check("to_ptr_adv", 64'(o_ack), 64'(4'b0010));
      i_req = 4'b0000;
      @(negedge i_clk);
      for (int k = 1; k <= 15; k++) @(negedge i_clk);
      man_done = 1'b1;
      @(negedge i_clk);
      man_done = 1'b0;
      check("to_coincident", 64'({o_done, o_err}), 64'({4'b0010, 1'b0}));
      i_req = 4'b0111;
      @(negedge i_clk);
      check("to_ptr_adv2", 64'(o_ack), 64'(4'b0100));
      i_req = 4'b0000;
      @(negedge i_clk);
      man_done = 1'b1;
      @(negedge i_clk);
      man_done = 1'b0;

      // Asynchronous reset in WAIT, then arbitration restarts from ptr 0
      do_reset();
      i_req = 4'b0100;
      @(negedge i_clk);
      i_req = 4'b0000;
      @(negedge i_clk);
      check("rst_in_wait", 64'({o_busy, o_grant}), 64'({1'b1, 4'b0100}));
      #2 i_reset = 1'b1;
      #1;
      check("rst_async", 64'({o_ack, o_done, o_err, o_grant, o_busy, o_tx_start, o_tx_data}), 64'd0);
      @(negedge i_clk);
      check("rst_no_pulse", 64'({o_done, o_err, o_busy}), 64'd0);
      i_reset = 1'b0;
      i_req   = 4'b1001;
      @(negedge i_clk);
      check("rst_ptr0", 64'(o_ack), 64'(4'b0001));
      i_req = 4'b0000;
      @(negedge i_clk);
      man_done = 1'b1;
      @(negedge i_clk);
      man_done = 1'b0;
      i_req = 4'b1000;
      @(negedge i_clk);
      check("rst_lane3", 64'(o_grant), 64'(4'b1000));
      i_req = 4'b0000;
      @(negedge i_clk);
      man_done = 1'b1;
      @(negedge i_clk);
      man_done = 1'b0;

      // Three back-to-back serial frames through the behavioural transmitter
      do_reset();
      uart_mode   = 1'b1;
      exp_byte[0] = 8'h55;
      exp_byte[1] = 8'h00;
      exp_byte[2] = 8'hFF;
      i_req_data  = 32'h00FF_0055;
      i_req       = 4'b0111;
      err_seen    = 1'b0;
      ack_q.delete();
      fork
         begin
            for (int k = 0; k < 90; k++) begin
               @(negedge i_clk);
               if (o_ack != 4'b0000) ack_q.push_back(o_ack);
               if (o_err) err_seen = 1'b1;
               i_req = i_req & ~o_ack;
            end
         end
         begin
            for (int f = 0; f < 3; f++) begin
               guard = 0;
               while (tx_line !== 1'b0 && guard < 60) begin
                  @(negedge i_clk);
                  guard++;
               end
               check($sformatf("uart_start%0d", f), 64'(guard < 60), 64'd1);
               for (int b = 0; b < 8; b++) begin
                  @(negedge i_clk);
                  rx[b] = tx_line;
               end
               @(negedge i_clk);
               check($sformatf("uart_frame%0d", f), 64'({tx_line, rx}), 64'({1'b1, exp_byte[f]}));
            end
         end
      join
      check("uart_no_err", 64'(err_seen), 64'd0);
      check("uart_ack_count", 64'(ack_q.size()), 64'd3);
      for (int k = 0; k < ack_q.size() && k < 3; k++)
         check($sformatf("uart_order%0d", k), 64'(ack_q[k]), 64'(4'b0001 << k));
      uart_mode = 1'b0;
      i_req     = 4'b0000;

      // Randomized traffic against a transaction-level reference model
      do_reset();
      m_ptr   = 0;
      m_owner = -1;
      m_age   = 0;
      e_data  = 8'h00;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         i_req      = ($urandom_range(0, 4) == 0) ? 4'b0000 : 4'($urandom_range(0, 15));
         i_req_mask = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
         i_req_data = $urandom();
         man_done   = ($urandom_range(0, 9) == 0);
         e_ack  = 4'b0000;
         e_done = 4'b0000;
         e_err  = 1'b0;
         if (m_owner < 0) begin
            elig = i_req & i_req_mask;
            for (int k = 0; k < 4; k++) begin
               c = (m_ptr + k) % 4;
               if (m_owner < 0 && elig[c]) begin
                  m_owner = c;
                  m_age   = 1;
                  e_ack   = 4'b0001 << c;
                  e_data  = i_req_data[c*8 +: 8];
               end
            end
         end else if (m_age == 1) begin
            m_age = 2;
         end else if (man_done) begin
            e_done  = 4'b0001 << m_owner;
            m_ptr   = (m_owner + 1) % 4;
            m_owner = -1;
         end else if (m_age - 2 == TIMEOUT - 1) begin
            e_err   = 1'b1;
            m_ptr   = (m_owner + 1) % 4;
            m_owner = -1;
         end else begin
            m_age++;
         end
         e_busy  = (m_owner >= 0);
         e_grant = e_busy ? (4'b0001 << m_owner) : 4'b0000;
         e_start = e_busy && (m_age == 1);
         @(negedge i_clk);
         check($sformatf("rand%0d", cyc), 64'({o_ack, o_done, o_err, o_grant, o_busy, o_tx_start}),
               64'({e_ack, e_done, e_err, e_grant, e_busy, e_start}));
         if (e_busy)
            check($sformatf("rand%0d_data", cyc), 64'(o_tx_data), 64'(e_data));
      end

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
